// File: rtl/sample_packer_pkg.sv
// Shared types for sample_packer: mode and state encodings plus the per-mode sample width.
package sample_packer_pkg;

    typedef enum logic [1:0] {
        MODE_IQ2    = 2'd0,
        MODE_RAW_I  = 2'd1,
        MODE_RAW_Q  = 2'd2,
        MODE_RAW_IQ = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int unsigned sample_width(input mode_e mode, input int unsigned nch);
        case (mode)
            MODE_IQ2:    return 4 * nch;
            MODE_RAW_IQ: return 16;
            default:     return 8;
        endcase
    endfunction

endpackage

// File: rtl/sample_packer_if.sv
// Bus bundle between the sample sources / packet sink and sample_packer.
// test_en exists only when SAMPLE_PACKER_TEST_PATTERN_EN is defined.
interface sample_packer_if #(
    parameter int unsigned NCH    = 3,
    parameter int unsigned WORD_W = 16
) ();
    localparam int unsigned SelW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              enable;
    logic [1:0]        mode;
    logic [SelW-1:0]   ch_sel;
    logic [2*NCH-1:0]  si;
    logic [2*NCH-1:0]  sq;
    logic [8*NCH-1:0]  raw_i;
    logic [8*NCH-1:0]  raw_q;
    logic [WORD_W-1:0] data;
    logic              valid;
    logic              packet_end;
    logic              busy;

`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
    logic              test_en;

    modport master (
        output enable, mode, ch_sel, si, sq, raw_i, raw_q, test_en,
        input  data, valid, packet_end, busy
    );
    modport slave (
        input  enable, mode, ch_sel, si, sq, raw_i, raw_q, test_en,
        output data, valid, packet_end, busy
    );
`else
    modport master (
        output enable, mode, ch_sel, si, sq, raw_i, raw_q,
        input  data, valid, packet_end, busy
    );
    modport slave (
        input  enable, mode, ch_sel, si, sq, raw_i, raw_q,
        output data, valid, packet_end, busy
    );
`endif

endinterface

// File: rtl/sample_packer_sample_select.sv
// Forms the right-justified sample vector and its width from the latched mode/ch_sel.
module sample_select
    import sample_packer_pkg::*;
#(
    parameter int unsigned NCH    = 3,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned SelW   = 2,
    parameter int unsigned FillW  = 6
) (
    input  mode_e             i_mode,
    input  logic [SelW-1:0]   i_ch_sel,
    input  logic [2*NCH-1:0]  i_si,
    input  logic [2*NCH-1:0]  i_sq,
    input  logic [8*NCH-1:0]  i_raw_i,
    input  logic [8*NCH-1:0]  i_raw_q,
    output logic [WORD_W-1:0] o_sample,
    output logic [FillW-1:0]  o_width
);
    logic [4*NCH-1:0] w_iq;
    logic [7:0]       w_ri;
    logic [7:0]       w_rq;

    always_comb begin
        w_iq = '0;
        for (int k = 0; k < NCH; k++) begin
            w_iq[4*(NCH-1-k) +: 4] = {i_si[2*k +: 2], i_sq[2*k +: 2]};
        end
        // Channel 0 is the default, so an out-of-range ch_sel simply never matches.
        w_ri = i_raw_i[7:0];
        w_rq = i_raw_q[7:0];
        for (int k = 1; k < NCH; k++) begin
            if (i_ch_sel == SelW'(k)) begin
                w_ri = i_raw_i[8*k +: 8];
                w_rq = i_raw_q[8*k +: 8];
            end
        end
        o_sample = '0;
        unique case (i_mode)
            MODE_IQ2:    o_sample = WORD_W'(w_iq);
            MODE_RAW_I:  o_sample = WORD_W'(w_ri);
            MODE_RAW_Q:  o_sample = WORD_W'(w_rq);
            MODE_RAW_IQ: o_sample = WORD_W'({w_ri, w_rq});
        endcase
        o_width = FillW'(sample_width(i_mode, NCH));
    end

endmodule

// File: rtl/sample_packer.sv
// Packs per-cycle ADC samples into WORD_W-bit words with a packet_end every PKT_WORDS words.
// Optional test-pattern source enabled by defining SAMPLE_PACKER_TEST_PATTERN_EN.
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter int unsigned NCH       = 3,
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned PKT_WORDS = 720
) (
    input  logic           clk,
    input  logic           rst,
    sample_packer_if.slave bus
);
    localparam int unsigned SelW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned AccW  = 2 * WORD_W;
    localparam int unsigned FillW = $clog2(AccW) + 1;
    localparam int unsigned CntW  = $clog2(PKT_WORDS);
    localparam logic [FillW-1:0] WordFill = FillW'(WORD_W);
    localparam logic [CntW-1:0]  LastCnt  = CntW'(PKT_WORDS - 1);

    state_e            r_state, w_state_nxt;
    mode_e             r_mode, w_mode_nxt;
    logic [SelW-1:0]   r_ch_sel, w_ch_sel_nxt;
    logic [AccW-1:0]   r_acc, w_acc_nxt;
    logic [FillW-1:0]  r_fill, w_fill_nxt;
    logic [CntW-1:0]   r_cnt, w_cnt_nxt;
    logic [WORD_W-1:0] r_data, w_data_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_pend, w_pend_nxt;

    logic [WORD_W-1:0] w_sel_sample;
    logic [WORD_W-1:0] w_sample;
    logic [FillW-1:0]  w_width;
    logic [FillW-1:0]  w_total;
    logic [FillW-1:0]  w_sh;
    logic [AccW-1:0]   w_shifted;
    logic              w_emit;
    logic              w_last;

    sample_select #(
        .NCH    (NCH),
        .WORD_W (WORD_W),
        .SelW   (SelW),
        .FillW  (FillW)
    ) u_sample_select (
        .i_mode   (r_mode),
        .i_ch_sel (r_ch_sel),
        .i_si     (bus.si),
        .i_sq     (bus.sq),
        .i_raw_i  (bus.raw_i),
        .i_raw_q  (bus.raw_q),
        .o_sample (w_sel_sample),
        .o_width  (w_width)
    );

`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
    logic              r_test, w_test_nxt;
    logic [WORD_W-1:0] r_pat, w_pat_nxt;
    logic [WORD_W-1:0] w_mask;

    // A width equal to WORD_W wraps the shift to zero, leaving an all-ones mask.
    assign w_mask   = (WORD_W'(1) << w_width) - WORD_W'(1);
    assign w_sample = r_test ? (r_pat & w_mask) : w_sel_sample;
`else
    assign w_sample = w_sel_sample;
`endif

    // Accumulator keeps the newest r_fill bits right-justified; bits above are stale.
    assign w_shifted = (r_acc << w_width) | AccW'(w_sample);
    assign w_total   = r_fill + w_width;
    assign w_emit    = (w_total >= WordFill);
    assign w_sh      = w_total - WordFill;
    assign w_last    = w_emit && (r_cnt == LastCnt);

    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_ch_sel_nxt = r_ch_sel;
        w_acc_nxt    = r_acc;
        w_fill_nxt   = r_fill;
        w_cnt_nxt    = r_cnt;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;
        w_pend_nxt   = 1'b0;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
        w_test_nxt   = r_test;
        w_pat_nxt    = r_pat;
`endif
        unique case (r_state)
            IDLE: begin
                if (bus.enable) begin
                    w_state_nxt  = RUN;
                    w_mode_nxt   = mode_e'(bus.mode);
                    w_ch_sel_nxt = bus.ch_sel;
                    w_acc_nxt    = '0;
                    w_fill_nxt   = '0;
                    w_cnt_nxt    = '0;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
                    w_test_nxt   = bus.test_en;
                    w_pat_nxt    = '0;
`endif
                end
            end
            RUN: begin
                w_acc_nxt  = w_shifted;
                w_fill_nxt = w_total;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
                w_pat_nxt  = r_pat + WORD_W'(1);
`endif
                if (w_emit) begin
                    w_data_nxt  = WORD_W'(w_shifted >> w_sh);
                    w_valid_nxt = 1'b1;
                    w_pend_nxt  = w_last;
                    w_fill_nxt  = w_sh;
                    w_cnt_nxt   = w_last ? '0 : r_cnt + CntW'(1);
                    if (w_last) begin
                        if (!bus.enable) begin
                            w_state_nxt = IDLE;
                            w_acc_nxt   = '0;
                            w_fill_nxt  = '0;
                        end else begin
                            w_mode_nxt   = mode_e'(bus.mode);
                            w_ch_sel_nxt = bus.ch_sel;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
                            w_test_nxt   = bus.test_en;
`endif
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mode   <= MODE_IQ2;
            r_ch_sel <= '0;
            r_acc    <= '0;
            r_fill   <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_ch_sel <= w_ch_sel_nxt;
            r_acc    <= w_acc_nxt;
            r_fill   <= w_fill_nxt;
            r_cnt    <= w_cnt_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_pend   <= w_pend_nxt;
        end
    end

`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_test <= 1'b0;
            r_pat  <= '0;
        end else begin
            r_test <= w_test_nxt;
            r_pat  <= w_pat_nxt;
        end
    end
`endif

    assign bus.data       = r_data;
    assign bus.valid      = r_valid;
    assign bus.packet_end = r_pend;
    assign bus.busy       = (r_state == RUN);

endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: bit-queue reference model feeding a scoreboard.
module tb_sample_packer;

    localparam int unsigned NCH       = 3;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned PKT_WORDS = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sample_packer_if #(.NCH(NCH), .WORD_W(WORD_W)) bus ();

    sample_packer #(
        .NCH       (NCH),
        .WORD_W    (WORD_W),
        .PKT_WORDS (PKT_WORDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[$];  // {packet_end, data}
    bit          bq[$];     // pending packed bits, oldest at the front
    bit          m_run = 1'b0;
    int          m_mode = 0;
    int          m_sel = 0;
    int          m_cnt = 0;
    bit          m_test = 1'b0;
    int unsigned m_pat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic int width_of(input int mode);
        return (mode == 0) ? 4 * NCH : ((mode == 3) ? 16 : 8);
    endfunction

    function automatic int unsigned sample_of(input int mode, input int sel);
        int unsigned si, sq, ri, rq, v;
        int ch;
        si = 32'(bus.si);
        sq = 32'(bus.sq);
        ri = 32'(bus.raw_i);
        rq = 32'(bus.raw_q);
        ch = (sel < NCH) ? sel : 0;
        v  = 0;
        case (mode)
            0: for (int k = 0; k < NCH; k++)
                v = (v << 4) | (((si >> (2 * k)) & 3) << 2) | ((sq >> (2 * k)) & 3);
            1: v = (ri >> (8 * ch)) & 255;
            2: v = (rq >> (8 * ch)) & 255;
            default: v = (((ri >> (8 * ch)) & 255) << 8) | ((rq >> (8 * ch)) & 255);
        endcase
        return v;
    endfunction

    task automatic latch();
        m_mode = int'(bus.mode);
        m_sel  = int'(bus.ch_sel);
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
        m_test = bus.test_en;
`else
        m_test = 1'b0;
`endif
    endtask

    // Applies the upcoming clock edge to the model using the inputs currently driven.
    task automatic model_step();
        int          s;
        int unsigned v, w;
        bit          last;
        if (!m_run) begin
            if (bus.enable) begin
                m_run = 1'b1;
                latch();
                bq.delete();
                m_cnt = 0;
                m_pat = 0;
            end
        end else begin
            s = width_of(m_mode);
            v = m_test ? (m_pat & ((32'd1 << s) - 1)) : sample_of(m_mode, m_sel);
            m_pat++;
            for (int b = s - 1; b >= 0; b--) bq.push_back(v[b]);
            if (bq.size() >= WORD_W) begin
                w = 0;
                for (int b = 0; b < WORD_W; b++) w = (w << 1) | 32'(bq.pop_front());
                last = (m_cnt == PKT_WORDS - 1);
                exp_q.push_back({last, w[15:0]});
                if (last) begin
                    m_cnt = 0;
                    if (!bus.enable) begin
                        m_run = 1'b0;
                        bq.delete();
                    end else begin
                        latch();
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("busy", 32'(bus.busy), 32'(m_run));
    endtask

    task automatic rand_data();
        bus.si    = 6'($urandom);
        bus.sq    = 6'($urandom);
        bus.raw_i = 24'($urandom);
        bus.raw_q = 24'($urandom);
    endtask

    task automatic go_idle();
        bus.enable = 1'b0;
        for (int i = 0; i < 200 && m_run; i++) step();
        check("reached_idle", 32'(bus.busy), 32'd0);
        step();
    endtask

    // Called at posedge+1; returns at posedge+1 with reset released.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_packet_end", 32'(bus.packet_end), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data", 32'(bus.data), 32'd0);
        exp_q.delete();
        bq.delete();
        m_run = 1'b0;
        m_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst) begin
            if (bus.valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=data 0x%0h required=no word", bus.data);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(bus.data), 32'(e[15:0]));
                    check("packet_end", 32'(bus.packet_end), 32'(e[16]));
                end
            end else begin
                check("packet_end_without_valid", 32'(bus.packet_end), 32'd0);
            end
        end
    end

    initial begin
        logic [7:0] cnt;
        bus.enable = 1'b0;
        bus.mode   = 2'd0;
        bus.ch_sel = '0;
        bus.si     = '0;
        bus.sq     = '0;
        bus.raw_i  = '0;
        bus.raw_q  = '0;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
        bus.test_en = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(bus.data), 32'd0);
        check("reset_valid", 32'(bus.valid), 32'd0);
        check("reset_packet_end", 32'(bus.packet_end), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        repeat (3) step();

        // Mode 0, constant 0xF05 sample.
        bus.mode   = 2'd0;
        bus.si     = 6'b010011;
        bus.sq     = 6'b010011;
        bus.enable = 1'b1;
        repeat (20) step();
        go_idle();

        // Mode 1, ch1 counting.
        bus.mode   = 2'd1;
        bus.ch_sel = 2'd1;
        bus.enable = 1'b1;
        cnt = 8'd0;
        for (int i = 0; i < 40; i++) begin
            bus.raw_i = {8'h00, cnt, 8'h00};
            bus.raw_q = 24'($urandom);
            cnt++;
            step();
        end
        go_idle();

        // Mode 3, ch2 constant.
        bus.mode   = 2'd3;
        bus.ch_sel = 2'd2;
        bus.raw_i  = 24'hAB1234;
        bus.raw_q  = 24'hCD5678;
        bus.enable = 1'b1;
        repeat (20) step();
        go_idle();

        // Mode/enable changes mid-packet are held off until the boundary.
        bus.mode   = 2'd0;
        bus.enable = 1'b1;
        repeat (4) begin rand_data(); step(); end
        bus.mode   = 2'd1;
        bus.enable = 1'b0;
        for (int i = 0; i < 40; i++) begin rand_data(); step(); end

        // Asynchronous reset mid-packet, restart with enable held.
        bus.mode   = 2'd3;
        bus.enable = 1'b1;
        repeat (4) begin rand_data(); step(); end
        mid_reset();
        repeat (20) begin rand_data(); step(); end
        go_idle();

`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
        bus.mode    = 2'd1;
        bus.test_en = 1'b1;
        bus.enable  = 1'b1;
        repeat (30) begin rand_data(); step(); end
        bus.test_en = 1'b0;
        go_idle();
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rand_data();
            if ($urandom_range(0, 7) == 0) begin
                bus.mode   = 2'($urandom);
                bus.ch_sel = 2'($urandom);
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
                bus.test_en = 1'($urandom);
`endif
            end
            bus.enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 399) == 0) mid_reset();
            else step();
        end

        go_idle();
        repeat (4) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_packer.md
Name: sample_packer

Overview:
- Generalised successor to the fixed 3-channel phase/mode sample multiplexer that feeds packet_streamer.
- Packs per-cycle ADC samples from NCH channels into WORD_W-bit words through a bit accumulator.
- Supports selectable sample formats and a packet-end marker every PKT_WORDS words.
- Sits between the quantizers / gray_to_binary outputs and packet_streamer, in the clk_adc domain.

Parameters:
- NCH, 3: number of RF channels; 4*NCH <= WORD_W.
- WORD_W, 16: output word width; must be 16 or 32.
- PKT_WORDS, 720: words per packet; >= 2.

Ports:
- clk  in  1  sample clock (clk_adc).
- reset  in  1  asynchronous, active-high.
- enable  in  1  streaming enable; sampled only at a packet boundary.
- mode  in  2  0 = 2-bit I/Q all channels; 1 = 8-bit raw I; 2 = 8-bit raw Q; 3 = 8-bit raw I and Q.
- ch_sel  in  $clog2(NCH)  channel used by modes 1–3.
- si  in  2*NCH  quantized I; channel k occupies bits [2k+1:2k].
- sq  in  2*NCH  quantized Q; same layout as si.
- raw_i  in  8*NCH  binary I; channel k occupies bits [8k+7:8k].
- raw_q  in  8*NCH  binary Q; same layout as raw_i.
- data  out  WORD_W  packed word.
- valid  out  1  data is valid this cycle.
- packet_end  out  1  asserted with valid on the last word of a packet.
- busy  out  1  packer is in RUN.

Behaviour:
- Reset values: data = 0, valid = 0, packet_end = 0, busy = 0. Accumulator, fill count and word counter are cleared; state is IDLE.
- Sample width per mode, S:
  - mode 0: S = 4*NCH, sample = {si[ch0],sq[ch0],si[ch1],sq[ch1],...}, channel 0 in the MSBs.
  - modes 1 and 2: S = 8.
  - mode 3: S = 16, sample = {raw_i[sel],raw_q[sel]}.
- Accumulator is 2*WORD_W bits; fill counter is $clog2(2*WORD_W)+1 bits.
- Each RUN cycle the accumulator appends S bits, MSB-first (oldest data in the MSBs), and fill += S.
- If fill+S >= WORD_W, the top WORD_W bits are emitted and fill becomes fill+S-WORD_W.
- Emission is registered: a word completed by the sample at cycle t has valid high at t+1. Latency is 1 cycle.
- valid is never high for two sample-groups in one cycle; at most one word per cycle is guaranteed because S <= WORD_W.
- Word counter counts emitted words 0..PKT_WORDS-1; packet_end = valid && count == PKT_WORDS-1; the counter then wraps to 0.
- State machine:
  - IDLE → RUN when enable = 1. On that transition, mode and ch_sel are latched, the accumulator and fill are cleared, and the counter is set to 0.
  - RUN → IDLE at a packet boundary (after the packet_end word) if enable = 0. Otherwise the packer stays in RUN and re-latches mode/ch_sel.
  - Changes to mode, ch_sel or enable in the middle of a packet are ignored until the boundary.
- Non-integer packing: leftover bits carry across packet boundaries, so the packet stream is continuous. A boundary taken into IDLE discards the leftover bits.
- ch_sel >= NCH: channel 0 is used.
- Asynchronous reset mid-packet: all outputs drop immediately; no partial packet_end is emitted.

Optional Feature:
- Macro: SAMPLE_PACKER_TEST_PATTERN_EN.
- Defined: an extra input test_en (1 bit) is present. When test_en is high at the packet-boundary latch, every sample is replaced by an S-bit free-running counter. The counter resets to 0 on entry to RUN and increments once per sample. Used for link BER checks.
- Undefined: no port and no counter logic; behaviour is as described above.

Decomposition:
- Shared package sample_packer_pkg:
  - mode encodings MODE_IQ2 = 0, MODE_RAW_I = 1, MODE_RAW_Q = 2, MODE_RAW_IQ = 3;
  - function sample_width(mode, NCH);
  - state encodings IDLE and RUN.
- One sub-module, sample_select: a combinational/registered mux that forms the sample vector and S from the latched mode/ch_sel. The packer core holds the accumulator, fill, counter and FSM.

Test Plan:
- NCH=3, WORD_W=16, PKT_WORDS=6, mode 0; si = sq constant with ch0=3, ch1=0, ch2=1 (sample 0xF05) → words 0xF05F, 0x05F0, 0x5F05 repeating; valid pattern 1,1,1,0 per 4 cycles; packet_end on the 6th word.
- mode 1, ch_sel=1, raw_i[ch1] counting 0x00,0x01,... → words 0x0001, 0x0203, ...; valid every other cycle, first one 2 cycles after the RUN entry sample.
- mode 3, ch_sel=2, raw_i=0xAB, raw_q=0xCD → data 0xABCD every cycle; packet_end every PKT_WORDS cycles.
- mode changed 0→1 and enable dropped mid-packet → current packet completes in mode 0 with a correct packet_end; busy then falls and valid stays 0.
- Reset asserted mid-packet, then released with enable = 1 → outputs go 0 asynchronously; the first packet after restart starts at word count 0 with a cleared accumulator.
- With SAMPLE_PACKER_TEST_PATTERN_EN, mode 1 and test_en = 1 → words 0x0001, 0x0203, ..., continuing across packets without a gap.
